apple_txt_fetch: RTL and testbench

Fetches one 40-character row of the Apple II text page from the host memory bus, using the interleaved text-page address map, into a ping-pong line buffer. Sits directly upstream of the video display processor. The renderer reads the completed ("front") row by column while the next row fills the "back" buffer. Runs entirely on CLOCK_50 and replaces linear `$400 + 40*row` addressing with the correct Apple II screen-hole layout.

---
 rtl/apple_txt_fetch_if.sv | 21 ++
 rtl/apple_txt_fetch.sv | 155 +++++++++++++++
 tb/tb_apple_txt_fetch.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apple_txt_fetch_if.sv
// -----------------------------------------------------------------------------
// apple_txt_fetch_if
//   Host memory read bus used by the Apple II text-row fetcher.
//
//   mem_req  fetcher -> memory  read request, held until acknowledged
//   mem_adr  fetcher -> memory  16-bit byte address, stable while mem_req
//   mem_ack  memory  -> fetcher byte on mem_d is valid at this edge
//   mem_d    memory  -> fetcher read data
//
//   master : the fetcher (drives request/address)
//   slave  : the memory  (drives acknowledge/data)
// -----------------------------------------------------------------------------
interface apple_txt_fetch_if;
    logic        mem_req;
    logic [15:0] mem_adr;
    logic        mem_ack;
    logic [7:0]  mem_d;

    modport master (output mem_req, output mem_adr, input mem_ack, input mem_d);
    modport slave  (input mem_req, input mem_adr, output mem_ack, output mem_d);
endinterface

// File: rtl/apple_txt_fetch.sv
// -----------------------------------------------------------------------------
// apple_txt_fetch
//   Fetches one 40-character row of the Apple II text page (page 1, $0400)
//   using the interleaved screen-hole address map, into a ping-pong line
//   buffer. The renderer reads the front buffer by column while the next row
//   fills the back buffer. Buffers swap in the FLIP cycle after the last byte.
//
//   Ports:
//     clk     in   system clock, posedge
//     reset   in   synchronous, active-low reset
//     start   in   one-cycle request to fetch row `row`
//     row     in   text row 0..23, sampled when start is accepted
//     busy    out  high from the accept cycle through FLIP
//     done    out  one-cycle pulse in FLIP (row complete, buffers swapping)
//     mem     master side of apple_txt_fetch_if (req/adr/ack/d)
//     rd_col  in   renderer column select
//     rd_q    out  registered front-buffer byte at rd_col (0 for rd_col >= 40)
//
//   Build option:
//     APPLE_TXT_NORMALIZE_EN  when defined, each byte is stored as
//       {inverse, 1'b0, glyph[5:0]}, inverse = (mem_d[7:6] == 2'b00);
//       flash codes are stored as normal. Otherwise bytes are stored raw.
// -----------------------------------------------------------------------------
module apple_txt_fetch (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        row,
    output logic              busy,
    output logic              done,
    apple_txt_fetch_if.master mem,
    input  logic [5:0]        rd_col,
    output logic [7:0]        rd_q
);
    localparam logic [15:0] BASE      = 16'h0400;
    localparam int          COLS      = 40;
    localparam int          ROWS      = 24;
    localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
    localparam logic [5:0]  COL_LIMIT = 6'(COLS);
    localparam logic [4:0]  ROW_LIMIT = 5'(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FLIP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_row;
    logic [5:0]  r_col;
    logic        r_front;
    logic [7:0]  r_buf [0:1][0:COLS-1];

    logic        w_accept;
    logic        w_capture;
    logic        w_last;
    logic [15:0] w_row_off;
    logic [15:0] w_grp_off;
    logic [7:0]  w_wr_byte;

    assign w_accept  = (r_state == ST_IDLE) && start && (row < ROW_LIMIT);
    assign w_capture = (r_state == ST_FETCH) && mem.mem_ack;
    assign w_last    = (r_col == LAST_COL);

    // Screen-hole map: 128 bytes per (row mod 8), 40 bytes per (row div 8).
    // 40*g is formed as 32*g + 8*g so the whole sum stays in 16 bits.
    assign w_row_off = {6'd0, r_row[2:0], 7'd0};
    assign w_grp_off = {9'd0, r_row[4:3], 5'd0} + {11'd0, r_row[4:3], 3'd0};

`ifdef APPLE_TXT_NORMALIZE_EN
    assign w_wr_byte = {(mem.mem_d[7:6] == 2'b00), 1'b0, mem.mem_d[5:0]};
`else
    assign w_wr_byte = mem.mem_d;
`endif

    // NOTE: every output and next-state value gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        mem.mem_req  = 1'b0;
        mem.mem_adr  = BASE + w_row_off + w_grp_off + {10'd0, r_col};
        done         = 1'b0;
        busy         = (r_state != ST_IDLE) || w_accept;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                if (w_capture && w_last) begin
                    w_state_next = ST_FLIP;
                end
            end
            ST_FLIP: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Row/column tracking and front select. r_row/r_col return to 0 on reset,
    // which parks mem_adr at BASE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_row   <= '0;
            r_col   <= '0;
            r_front <= 1'b0;
        end else begin
            if (w_accept) begin
                r_row <= row;
                r_col <= '0;
            end else if (w_capture && !w_last) begin
                r_col <= r_col + 6'd1;
            end
            if (r_state == ST_FLIP) begin
                r_front <= ~r_front;
            end
        end
    end

    // NOTE: the line buffers are plain storage and are deliberately not reset;
    // a reset term would stop them mapping onto RAM. Writes are still blocked
    // while reset is low so an abandoned row leaves nothing behind at that edge.
    always_ff @(posedge clk) begin
        if (reset && w_capture) begin
            r_buf[~r_front][r_col] <= w_wr_byte;
        end
    end

    // Renderer read port; reads on the swap edge still see the old front.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q <= 8'h00;
        end else if (rd_col < COL_LIMIT) begin
            rd_q <= r_buf[r_front][rd_col];
        end else begin
            rd_q <= 8'h00;
        end
    end

endmodule

// File: tb/tb_apple_txt_fetch.sv
// -----------------------------------------------------------------------------
// tb_apple_txt_fetch
//   Directed bench for apple_txt_fetch. The memory returns
//   (address - $0400)[7:0] ^ data_xor. A behavioural model tracks the fetch
//   position, both line buffers and the front select from the address-map and
//   storage rules, and a compare process checks every output on each negedge.
//   Hand-computed literal expectations pin the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apple_txt_fetch;
    localparam int COLS = 40;
    localparam int ROWS = 24;

`ifdef APPLE_TXT_NORMALIZE_EN
    localparam logic [7:0] EXP_C5   = 8'h85;
    localparam logic [7:0] EXP_C20  = 8'h94;
    localparam logic [7:0] EXP_N01  = 8'h81;
    localparam logic [7:0] EXP_N41  = 8'h01;
    localparam logic [7:0] EXP_NC1  = 8'h01;
`else
    localparam logic [7:0] EXP_C5   = 8'h05;
    localparam logic [7:0] EXP_C20  = 8'h14;
    localparam logic [7:0] EXP_N01  = 8'h01;
    localparam logic [7:0] EXP_N41  = 8'h41;
    localparam logic [7:0] EXP_NC1  = 8'hC1;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       start  = 1'b0;
    logic [4:0] row    = '0;
    logic [5:0] rd_col = '0;
    logic       busy;
    logic       done;
    logic [7:0] rd_q;
    logic [7:0] data_xor = 8'h00;
    logic [15:0] w_off;
    bit         cmp_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    apple_txt_fetch_if mif();

    apple_txt_fetch dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .row    (row),
        .busy   (busy),
        .done   (done),
        .mem    (mif),
        .rd_col (rd_col),
        .rd_q   (rd_q)
    );

    always #10 clk = ~clk;

    // Memory: combinational read data derived from the address.
    assign w_off     = mif.mem_adr - 16'h0400;
    assign mif.mem_d = w_off[7:0] ^ data_xor;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int exp_addr(input int r, input int c);
        return 'h400 + 128 * (r % 8) + 40 * (r / 8) + c;
    endfunction

    function automatic logic [7:0] mem_value(input int r, input int c);
        int v;
        v = exp_addr(r, c) - 'h400;
        return 8'(v % 256) ^ data_xor;
    endfunction

    function automatic logic [7:0] stored(input logic [7:0] d);
`ifdef APPLE_TXT_NORMALIZE_EN
        if (d < 8'h40) return 8'h80 + d;
        else           return 8'(d % 64);
`else
        return d;
`endif
    endfunction

    int         m_pos   = -1;   // -1 idle, 0..39 column being fetched, 40 flip
    int         m_row   = 0;
    int         m_front = 0;
    logic [7:0] m_buf   [2][COLS];
    bit         m_known [2][COLS];
    logic [7:0] m_rdq   = 8'h00;
    bit         m_rdq_known = 1'b1;

    task automatic model_step();
        if (!reset) begin
            m_pos       = -1;
            m_row       = 0;
            m_front     = 0;
            m_rdq       = 8'h00;
            m_rdq_known = 1'b1;
        end else begin
            if (rd_col < COLS) begin
                m_rdq       = m_buf[m_front][rd_col];
                m_rdq_known = m_known[m_front][rd_col];
            end else begin
                m_rdq       = 8'h00;
                m_rdq_known = 1'b1;
            end
            if (m_pos == -1) begin
                if (start && row < ROWS) begin
                    m_row = row;
                    m_pos = 0;
                end
            end else if (m_pos == COLS) begin
                m_front = 1 - m_front;
                m_pos   = -1;
            end else if (mif.mem_ack) begin
                m_buf[1 - m_front][m_pos]   = stored(mem_value(m_row, m_pos));
                m_known[1 - m_front][m_pos] = 1'b1;
                m_pos++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("mem_req", mif.mem_req, (m_pos >= 0 && m_pos < COLS));
                if (m_pos >= 0 && m_pos < COLS)
                    check("mem_adr", mif.mem_adr, exp_addr(m_row, m_pos));
                check("done", done, (m_pos == COLS));
                check("busy", busy, (m_pos != -1) || (start && row < ROWS));
                if (m_rdq_known)
                    check("rd_q", rd_q, m_rdq);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    // Runs one row; returns the cycle (0 = cycle after the accept edge) in
    // which done was seen, the first address, the last acked address and the
    // number of acked requests. poke_k >= 0 raises start (row 3) in that cycle.
    task automatic run_row(input int r, input bit toggle, input int poke_k,
                           output int done_k, output logic [15:0] first_adr,
                           output logic [15:0] last_adr, output int n_cap);
        @(posedge clk); #1;
        start       = 1'b1;
        row         = 5'(r);
        mif.mem_ack = 1'b1;
        done_k      = -1;
        n_cap       = 0;
        first_adr   = '0;
        last_adr    = '0;
        for (int k = 0; k < 200 && done_k < 0; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == poke_k) begin
                start = 1'b1;
                row   = 5'd3;
            end
            if (done) done_k = k;
            if (k == 0) first_adr = mif.mem_adr;
            mif.mem_ack = toggle ? (k % 2 == 0) : 1'b1;
            if (mif.mem_req && mif.mem_ack) begin
                last_adr = mif.mem_adr;
                n_cap++;
            end
        end
        start       = 1'b0;
        mif.mem_ack = 1'b0;
        if (done_k < 0) begin
            checks++;
            failures++;
            $display("FAIL row_timeout: row %0d got no done within 200 cycles", r);
        end
    endtask

    task automatic read_col(input logic [5:0] c, input string name, input logic [7:0] exp);
        rd_col = c;
        repeat (2) @(posedge clk);
        #1;
        check(name, rd_q, exp);
    endtask

    initial begin
        int          dk;
        int          nc;
        int          dcnt;
        logic [15:0] fa;
        logic [15:0] la;

        mif.mem_ack = 1'b0;
        reset       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("rst_busy",    busy,        1'b0);
        check("rst_done",    done,        1'b0);
        check("rst_mem_req", mif.mem_req, 1'b0);
        check("rst_mem_adr", mif.mem_adr, 16'h0400);
        check("rst_rd_q",    rd_q,        8'h00);
        reset = 1'b1;

        // Row 0, ack held high.
        run_row(0, 1'b0, -1, dk, fa, la, nc);
        check("r0_first", fa, 16'h0400);
        check("r0_last",  la, 16'h0427);
        check("r0_done_k", dk, 40);
        check("r0_ncap",  nc, 40);
        rd_col = 6'd5;
        @(posedge clk); #1;          // swap edge: old front still read
        @(posedge clk); #1;          // new front visible
        check("r0_rd5", rd_q, EXP_C5);
        read_col(6'd45, "rd_out_of_range", 8'h00);

        run_row(9, 1'b0, -1, dk, fa, la, nc);
        check("r9_first", fa, 16'h04A8);
        check("r9_last",  la, 16'h04CF);

        run_row(23, 1'b0, -1, dk, fa, la, nc);
        check("r23_first", fa, 16'h07D0);
        check("r23_last",  la, 16'h07F7);

        // Row 0 with ack toggling 1-0-1.
        run_row(0, 1'b1, -1, dk, fa, la, nc);
        check("tog_done_k", dk, 79);
        check("tog_ncap",   nc, 40);
        check("tog_last",   la, 16'h0427);

        run_row(9, 1'b0, -1, dk, fa, la, nc);

        // Row 5 abandoned by reset at column 17.
        @(posedge clk); #1;
        start       = 1'b1;
        row         = 5'd5;
        mif.mem_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("r5_col17_adr", mif.mem_adr, 16'h0691);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_req",  mif.mem_req, 1'b0);
        check("rst_mid_busy", busy,        1'b0);
        reset       = 1'b1;
        mif.mem_ack = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("rst_no_done", dcnt, 0);
        read_col(6'd20, "rst_front0_rd20", EXP_C20);

        // Row 1 after reset, with a start poked while busy.
        run_row(1, 1'b0, 10, dk, fa, la, nc);
        check("r1_first",  fa, 16'h0480);
        check("r1_done_k", dk, 40);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_queued_req", mif.mem_req, 1'b0);
        end

        // Out-of-range row is ignored.
        start = 1'b1;
        row   = 5'd24;
        #2;
        check("row24_busy", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("row24_no_req", mif.mem_req, 1'b0);
        end

        // Storage format for $01, $41, $C1 at column 1.
        data_xor = 8'h00;
        run_row(0, 1'b0, -1, dk, fa, la, nc);
        read_col(6'd1, "store_01", EXP_N01);
        data_xor = 8'h40;
        run_row(0, 1'b0, -1, dk, fa, la, nc);
        read_col(6'd1, "store_41", EXP_N41);
        data_xor = 8'hC0;
        run_row(0, 1'b0, -1, dk, fa, la, nc);
        read_col(6'd1, "store_C1", EXP_NC1);

        repeat (3) @(posedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
